mem_port_arbiter: RTL and testbench

- Parametrised successor to the single-ported fetch/data memory mux in the pipelined MIPS core.
- Arbitrates N_PORTS requesters (port 0 = data/MEM stage, port 1 = instruction fetch, others for future DMA/debug) onto one pipelined shared-memory port.
- Tracks in-flight reads and routes each response to the requester that issued it.
- Supports per-port flush (e.g. IF flush on branch/jump) and starvation-bounded fixed priority.

---
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: N-port arbiter onto a pipelined shared memory with read-tag response routing and per-port flush.
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority with a starvation guard.
module mem_port_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [N_PORTS-1:0]         req_valid,
  input  logic [N_PORTS-1:0]         req_we,
  input  logic [N_PORTS*ADDR_W-1:0]  req_addr,
  input  logic [N_PORTS*DATA_W-1:0]  req_wdata,
  output logic [N_PORTS-1:0]         req_ready,
  input  logic [N_PORTS-1:0]         flush,
  output logic [N_PORTS-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_rd,
  output logic                       mem_wr,
  input  logic [DATA_W-1:0]          mem_rdata
);
  localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  logic          gnt_any;
  logic [PW-1:0] gnt_id;
  logic          acc_rd;
  logic [READ_LAT:0] tag_v;
  logic [PW-1:0]     tag_id [READ_LAT+1];
`ifdef ARB_RR_EN
  logic [PW-1:0] rr_ptr;
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_PORTS;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = PW'(idx);
      end
    end
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= (gnt_id == PW'(N_PORTS - 1)) ? '0 : gnt_id + PW'(1);
`else
  localparam int CW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
  logic [CW-1:0]      starve_cnt [N_PORTS];
  logic [N_PORTS-1:0] starved;
  logic [N_PORTS-1:0] cand;
  always_comb begin
    starved = '0;
    for (int i = 1; i < N_PORTS; i++)
      starved[i] = STARVE_MAX > 0 && req_valid[i] && starve_cnt[i] == CW'(STARVE_MAX);
    // starved ports outrank everyone; lowest index wins within the chosen set
    cand    = |starved ? starved : req_valid;
    gnt_any = |cand;
    gnt_id  = '0;
    for (int i = N_PORTS - 1; i >= 0; i--)
      if (cand[i]) gnt_id = PW'(i);
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) for (int i = 0; i < N_PORTS; i++) starve_cnt[i] <= '0;
    else
      for (int i = 1; i < N_PORTS; i++)
        starve_cnt[i] <= (!req_valid[i] || req_ready[i]) ? '0 :
                         (starve_cnt[i] == CW'(STARVE_MAX)) ? starve_cnt[i] : starve_cnt[i] + CW'(1);
`endif
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_PORTS; i++) req_ready[i] = gnt_any && gnt_id == PW'(i);
  end
  assign acc_rd = gnt_any && !req_we[gnt_id];
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      tag_v     <= '0;
      for (int k = 0; k <= READ_LAT; k++) tag_id[k] <= '0;
    end else begin
      mem_rd <= acc_rd;
      mem_wr <= gnt_any && req_we[gnt_id];
      if (gnt_any) begin
        mem_addr  <= req_addr[gnt_id*ADDR_W +: ADDR_W];
        mem_wdata <= req_wdata[gnt_id*DATA_W +: DATA_W];
      end
      // a tag entering this cycle is never hit by this cycle's flush
      tag_v[0]  <= acc_rd;
      tag_id[0] <= gnt_id;
      for (int k = 1; k <= READ_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1] && !flush[tag_id[k-1]];
        tag_id[k] <= tag_id[k-1];
      end
    end
  always_comb begin
    rsp_valid = '0;
    if (tag_v[READ_LAT] && !flush[tag_id[READ_LAT]]) rsp_valid[tag_id[READ_LAT]] = 1'b1;
  end
  assign rsp_rdata = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector bench for mem_port_arbiter, 2 ports, READ_LAT=2, STARVE_MAX=4.
module tb_mem_port_arbiter;
  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid, req_we, flush, req_ready, rsp_valid;
  logic [31:0] a0, a1;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] ap0, ap1;
  int          n_cmp = 0, n_err = 0;

  typedef struct {
    logic [1:0]  v, we, fl;
    logic [31:0] a0, a1;
    logic [1:0]  rdy, rsp;
    logic        rd, wr;
    logic [31:0] ma, rdat;
  } vec_t;
  vec_t tbl[$];

  always #5 clock = ~clock;
  assign req_addr  = {a1, a0};
  assign req_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
  // memory returns the inverted address two cycles after the strobe cycle
  always @(posedge clock) begin
    ap0 <= mem_addr;
    ap1 <= ap0;
  end
  assign mem_rdata = ~ap1;

  mem_port_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .READ_LAT(2), .STARVE_MAX(4)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, we, fl, input logic [31:0] x0, x1);
    req_valid = v; req_we = we; flush = fl; a0 = x0; a1 = x1;
  endtask

  task automatic cyc(input logic [1:0] v, we, fl, input logic [31:0] x0, x1);
    @(posedge clock);
    #1 drive(v, we, fl, x0, x1);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    // v, we, fl, a0, a1 | rdy, rsp, rd, wr, ma, rdat
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0});
    tbl.push_back('{2'b10, 2'b00, 2'b00, 32'h0,   32'h40,  2'b10, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b1, 1'b0, 32'h40,  32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b0, 1'b0, 32'h40,  32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b10, 1'b0, 1'b0, 32'h40,  32'hFFFF_FFBF});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 32'h10,  32'h0,   2'b01, 2'b00, 1'b0, 1'b0, 32'h40,  32'h0});
    tbl.push_back('{2'b10, 2'b00, 2'b00, 32'h0,   32'h20,  2'b10, 2'b00, 1'b1, 1'b0, 32'h10,  32'h0});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 32'h30,  32'h0,   2'b01, 2'b00, 1'b1, 1'b0, 32'h20,  32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b01, 1'b1, 1'b0, 32'h30,  32'hFFFF_FFEF});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b10, 1'b0, 1'b0, 32'h30,  32'hFFFF_FFDF});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b01, 1'b0, 1'b0, 32'h30,  32'hFFFF_FFCF});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b0, 1'b0, 32'h30,  32'h0});
    tbl.push_back('{2'b10, 2'b00, 2'b00, 32'h0,   32'h100, 2'b10, 2'b00, 1'b0, 1'b0, 32'h30,  32'h0});
    tbl.push_back('{2'b10, 2'b00, 2'b00, 32'h0,   32'h104, 2'b10, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0});
    tbl.push_back('{2'b10, 2'b00, 2'b10, 32'h0,   32'h108, 2'b10, 2'b00, 1'b1, 1'b0, 32'h104, 32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b1, 1'b0, 32'h108, 32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b0, 1'b0, 32'h108, 32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b10, 1'b0, 1'b0, 32'h108, 32'hFFFF_FEF7});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 32'h200, 32'h0,   2'b01, 2'b00, 1'b0, 1'b0, 32'h108, 32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b1, 1'b0, 32'h200, 32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b0, 1'b0, 32'h200, 32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b01, 32'h0,   32'h0,   2'b00, 2'b00, 1'b0, 1'b0, 32'h200, 32'h0});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 32'h300, 32'h0,   2'b01, 2'b00, 1'b0, 1'b0, 32'h200, 32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b1, 1'b0, 32'h300, 32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b0, 1'b0, 32'h300, 32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b10, 32'h0,   32'h0,   2'b00, 2'b01, 1'b0, 1'b0, 32'h300, 32'hFFFF_FCFF});
    tbl.push_back('{2'b01, 2'b01, 2'b00, 32'h44,  32'h0,   2'b01, 2'b00, 1'b0, 1'b0, 32'h300, 32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b0, 1'b1, 32'h44,  32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b0, 1'b0, 32'h44,  32'h0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 1'b0, 1'b0, 32'h44,  32'h0});
    repeat (2) @(posedge clock);
    #1;
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
    chk("reset rsp_valid", {30'h0, rsp_valid}, 32'h0);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].we, tbl[i].fl, tbl[i].a0, tbl[i].a1);
      chk($sformatf("vec%0d req_ready", i), {30'h0, req_ready}, {30'h0, tbl[i].rdy});
      chk($sformatf("vec%0d rsp_valid", i), {30'h0, rsp_valid}, {30'h0, tbl[i].rsp});
      chk($sformatf("vec%0d mem_rd/wr", i), {30'h0, mem_rd, mem_wr}, {30'h0, tbl[i].rd, tbl[i].wr});
      chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].ma);
      if (tbl[i].rsp != 2'b00) chk($sformatf("vec%0d rsp_rdata", i), rsp_rdata, tbl[i].rdat);
      if (tbl[i].wr) chk($sformatf("vec%0d mem_wdata", i), mem_wdata, 32'hAAAA_0000);
    end

    // contention: port0 writes, port1 reads, both always valid
    for (int k = 0; k < 13; k++) begin
      cyc(k < 10 ? 2'b11 : 2'b00, 2'b01, 2'b00, 32'h80, 32'h90);
      chk($sformatf("cont%0d req_ready", k), {30'h0, req_ready},
          k >= 10 ? 32'h0 : (k == 4 || k == 9) ? 32'h2 : 32'h1);
      chk($sformatf("cont%0d mem_rd/wr", k), {30'h0, mem_rd, mem_wr},
          (k == 5 || k == 10) ? 32'h2 : (k >= 1 && k <= 9) ? 32'h1 : 32'h0);
      chk($sformatf("cont%0d rsp_valid", k), {30'h0, rsp_valid}, (k == 7 || k == 12) ? 32'h2 : 32'h0);
      if (k == 7) chk("cont rsp_rdata", rsp_rdata, 32'hFFFF_FF6F);
    end

    // reset with two reads in flight
    cyc(2'b01, 2'b00, 2'b00, 32'h500, 32'h0);
    chk("rst0 req_ready", {30'h0, req_ready}, 32'h1);
    cyc(2'b10, 2'b00, 2'b00, 32'h0, 32'h600);
    chk("rst1 mem_addr", mem_addr, 32'h500);
    cyc(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    chk("rst2 mem_addr", mem_addr, 32'h600);
    resetn = 1'b0;
    #1;
    chk("rst async mem_addr", mem_addr, 32'h0);
    chk("rst async mem_wdata", mem_wdata, 32'h0);
    chk("rst async strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
    chk("rst async rsp_valid", {30'h0, rsp_valid}, 32'h0);
    @(posedge clock);
    @(negedge clock) resetn = 1'b1;
    #1 chk("post-rst rsp_valid", {30'h0, rsp_valid}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
      chk($sformatf("post-rst%0d rsp_valid", k), {30'h0, rsp_valid}, 32'h0);
    end
    cyc(2'b10, 2'b00, 2'b00, 32'h0, 32'h700);
    chk("after-rst req_ready", {30'h0, req_ready}, 32'h2);
    cyc(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    chk("after-rst mem_rd", {31'h0, mem_rd}, 32'h1);
    chk("after-rst mem_addr", mem_addr, 32'h700);
    cyc(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    chk("after-rst early rsp", {30'h0, rsp_valid}, 32'h0);
    cyc(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    chk("after-rst rsp_valid", {30'h0, rsp_valid}, 32'h2);
    chk("after-rst rsp_rdata", rsp_rdata, 32'hFFFF_F8FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
